// File: rtl/key_cmd_pkg.sv
// Shared constants for the keyboard command decoder: command codes,
// scancodes and the repeat-timer state encoding.
package key_cmd_pkg;

  localparam int CMD_W = 3;
  localparam int NCMD  = 7;

  typedef enum logic [CMD_W-1:0] {
    CMD_UP      = 3'd0,
    CMD_DOWN    = 3'd1,
    CMD_LEFT    = 3'd2,
    CMD_RIGHT   = 3'd3,
    CMD_SELECT  = 3'd4,
    CMD_CANCEL  = 3'd5,
    CMD_RESTART = 3'd6
  } cmd_e;

  // Extended (E0-prefixed) scancodes
  localparam logic [7:0] SC_ARROW_UP    = 8'h75;
  localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
  localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
  // Plain scancodes
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_R     = 8'h2D;

  typedef enum logic {
    REP_IDLE = 1'b0,
    REP_RUN  = 1'b1
  } rep_state_e;

  function automatic logic is_dir(input cmd_e c);
    return (c == CMD_UP) || (c == CMD_DOWN) || (c == CMD_LEFT) || (c == CMD_RIGHT);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty; a push while
// full is accepted only when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/key_cmd_decoder.sv
// PS/2 key events to cursor commands: registered decode, held-key
// tracking with typematic suppression, direction auto-repeat, command FIFO.
module key_cmd_decoder
  import key_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      key_in,
  input  logic            is_extend,
  input  logic            is_break,
  input  logic            key_valid,
  output logic [2:0]      cmd,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic [NCMD-1:0] held,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam bit REP_EN  = (REPEAT_DELAY != 0);

  logic            dec_hit;
  cmd_e            dec_code;
  logic            s1_hit;
  logic            s1_brk;
  cmd_e            s1_code;
  logic [NCMD-1:0] code_mask;
  logic [NCMD-1:0] rep_mask;
  logic [NCMD-1:0] held_n;
  logic            key_push;
  logic            dir_load;
  rep_state_e      rep_state, rep_state_n;
  cmd_e            rep_code, rep_code_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            rep_stop;
  logic            rep_push;
  logic            push;
  logic [CMD_W-1:0] push_code;
  logic            pop;
  logic            full;
  logic            empty;
  logic            ovf_set;

  always_comb begin
    dec_hit  = 1'b0;
    dec_code = CMD_UP;
    if (is_extend) begin
      case (key_in)
        SC_ARROW_UP:    begin dec_hit = 1'b1; dec_code = CMD_UP;     end
        SC_ARROW_DOWN:  begin dec_hit = 1'b1; dec_code = CMD_DOWN;   end
        SC_ARROW_LEFT:  begin dec_hit = 1'b1; dec_code = CMD_LEFT;   end
        SC_ARROW_RIGHT: begin dec_hit = 1'b1; dec_code = CMD_RIGHT;  end
        SC_ENTER:       begin dec_hit = 1'b1; dec_code = CMD_SELECT; end
        default: ;
      endcase
    end else begin
      case (key_in)
        SC_W:     begin dec_hit = 1'b1; dec_code = CMD_UP;      end
        SC_S:     begin dec_hit = 1'b1; dec_code = CMD_DOWN;    end
        SC_A:     begin dec_hit = 1'b1; dec_code = CMD_LEFT;    end
        SC_D:     begin dec_hit = 1'b1; dec_code = CMD_RIGHT;   end
        SC_ENTER: begin dec_hit = 1'b1; dec_code = CMD_SELECT;  end
        SC_SPACE: begin dec_hit = 1'b1; dec_code = CMD_SELECT;  end
        SC_ESC:   begin dec_hit = 1'b1; dec_code = CMD_CANCEL;  end
        SC_R:     begin dec_hit = 1'b1; dec_code = CMD_RESTART; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_hit  <= 1'b0;
      s1_brk  <= 1'b0;
      s1_code <= CMD_UP;
    end else begin
      s1_hit  <= key_valid && dec_hit;
      s1_brk  <= is_break;
      s1_code <= dec_code;
    end
  end

  // Aliased keys decode to the same code, so they share one held bit.
  assign code_mask = NCMD'(1) << s1_code;
  assign rep_mask  = NCMD'(1) << rep_code;
  assign key_push  = s1_hit && !s1_brk && ((held & code_mask) == '0);
  assign dir_load  = REP_EN && key_push && is_dir(s1_code);

  always_comb begin
    held_n = held;
    if (s1_hit) held_n = s1_brk ? (held & ~code_mask) : (held | code_mask);
  end

  // A break of the repeating key stops the timer in the same cycle it is
  // applied, so an expiry coinciding with that break never pushes.
  assign rep_stop = (s1_hit && s1_brk && (s1_code == rep_code)) || ((held & rep_mask) == '0);

  always_comb begin
    rep_state_n = rep_state;
    rep_code_n  = rep_code;
    cnt_n       = cnt;
    rep_push    = 1'b0;
    if (dir_load) begin
      rep_state_n = REP_RUN;
      rep_code_n  = s1_code;
      cnt_n       = CW'(REPEAT_DELAY - 1);
    end else if (rep_state == REP_RUN) begin
      if (rep_stop) begin
        rep_state_n = REP_IDLE;
      end else if (cnt == '0) begin
        if (!key_push) begin
          rep_push = 1'b1;
          cnt_n    = CW'(REPEAT_PERIOD - 1);
        end
      end else begin
        cnt_n = cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held      <= '0;
      rep_state <= REP_IDLE;
      rep_code  <= CMD_UP;
      cnt       <= '0;
      overflow  <= 1'b0;
    end else begin
      held      <= held_n;
      rep_state <= rep_state_n;
      rep_code  <= rep_code_n;
      cnt       <= cnt_n;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign push      = key_push || rep_push;
  assign push_code = key_push ? s1_code : rep_code;
  assign pop       = cmd_valid && cmd_ready;
  assign ovf_set   = push && full && !pop;
  assign cmd_valid = !empty;

  cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(push_code),
    .full (full),
    .pop  (pop),
    .rdata(cmd),
    .empty(empty)
  );

endmodule

// File: tb/tb_key_cmd_decoder.sv
// Directed bench for key_cmd_decoder: decode/held vector table plus
// hand-written repeat, overflow, full-FIFO, collision and reset sequences.
module tb_key_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] key_in = '0;
  logic       is_extend = 1'b0;
  logic       is_break = 1'b0;
  logic       key_valid = 1'b0;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [6:0] held;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int pop_q[$];
  int pop_cyc[$];

  key_cmd_decoder #(
    .FIFO_DEPTH(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .is_extend(is_extend),
    .is_break(is_break), .key_valid(key_valid), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .held(held), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted handshake with the cycle it happened in.
  always @(negedge clk) begin
    if (rst && cmd_valid && cmd_ready) begin
      pop_q.push_back(int'(cmd));
      pop_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic       ext;
    logic       brk;
    logic [7:0] key;
    logic       push;
    logic [2:0] code;
    logic [6:0] hld;
  } vec_t;

  vec_t tbl[28];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic ext, input logic brk, input logic [7:0] key);
    key_in = key; is_extend = ext; is_break = brk; key_valid = 1'b1;
    tick();
    key_valid = 1'b0; is_extend = 1'b0; is_break = 1'b0; key_in = '0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic drain_expect(input string nm, input int e0, input int e1, input int e2, input int e3);
    int base;
    int exp_a[4];
    exp_a[0] = e0; exp_a[1] = e1; exp_a[2] = e2; exp_a[3] = e3;
    base = pop_q.size();
    cmd_ready = 1'b1;
    repeat (8) tick();
    cmd_ready = 1'b0;
    chk({nm, "_count"}, pop_q.size() - base, 4);
    for (int i = 0; i < 4 && base + i < pop_q.size(); i++)
      chk($sformatf("%s_pop%0d", nm, i), pop_q[base + i], exp_a[i]);
    @(negedge clk);
    chk({nm, "_empty"}, int'(cmd_valid), 0);
    tick();
  endtask

  initial begin
    int base, t0, n;
    int offs[3];

    tbl[0]  = '{1'b1, 1'b0, 8'h75, 1'b1, 3'd0, 7'b0000001};
    tbl[1]  = '{1'b1, 1'b1, 8'h75, 1'b0, 3'd0, 7'b0000000};
    tbl[2]  = '{1'b0, 1'b0, 8'h1C, 1'b1, 3'd2, 7'b0000100};
    tbl[3]  = '{1'b0, 1'b0, 8'h1C, 1'b0, 3'd0, 7'b0000100};
    tbl[4]  = '{1'b1, 1'b0, 8'h6B, 1'b0, 3'd0, 7'b0000100};
    tbl[5]  = '{1'b0, 1'b1, 8'h1C, 1'b0, 3'd0, 7'b0000000};
    tbl[6]  = '{1'b0, 1'b0, 8'h1D, 1'b1, 3'd0, 7'b0000001};
    tbl[7]  = '{1'b1, 1'b0, 8'h75, 1'b0, 3'd0, 7'b0000001};
    tbl[8]  = '{1'b1, 1'b1, 8'h75, 1'b0, 3'd0, 7'b0000000};
    tbl[9]  = '{1'b0, 1'b0, 8'h15, 1'b0, 3'd0, 7'b0000000};
    tbl[10] = '{1'b1, 1'b0, 8'h1D, 1'b0, 3'd0, 7'b0000000};
    tbl[11] = '{1'b0, 1'b0, 8'h5A, 1'b1, 3'd4, 7'b0010000};
    tbl[12] = '{1'b1, 1'b0, 8'h5A, 1'b0, 3'd0, 7'b0010000};
    tbl[13] = '{1'b1, 1'b1, 8'h5A, 1'b0, 3'd0, 7'b0000000};
    tbl[14] = '{1'b0, 1'b0, 8'h29, 1'b1, 3'd4, 7'b0010000};
    tbl[15] = '{1'b0, 1'b1, 8'h29, 1'b0, 3'd0, 7'b0000000};
    tbl[16] = '{1'b0, 1'b0, 8'h76, 1'b1, 3'd5, 7'b0100000};
    tbl[17] = '{1'b0, 1'b1, 8'h76, 1'b0, 3'd0, 7'b0000000};
    tbl[18] = '{1'b0, 1'b0, 8'h2D, 1'b1, 3'd6, 7'b1000000};
    tbl[19] = '{1'b0, 1'b1, 8'h2D, 1'b0, 3'd0, 7'b0000000};
    tbl[20] = '{1'b1, 1'b0, 8'h72, 1'b1, 3'd1, 7'b0000010};
    tbl[21] = '{1'b0, 1'b1, 8'h1B, 1'b0, 3'd0, 7'b0000000};
    tbl[22] = '{1'b1, 1'b0, 8'h74, 1'b1, 3'd3, 7'b0001000};
    tbl[23] = '{1'b0, 1'b1, 8'h23, 1'b0, 3'd0, 7'b0000000};
    tbl[24] = '{1'b1, 1'b0, 8'h2D, 1'b0, 3'd0, 7'b0000000};
    tbl[25] = '{1'b0, 1'b1, 8'h15, 1'b0, 3'd0, 7'b0000000};
    tbl[26] = '{1'b0, 1'b0, 8'h1B, 1'b1, 3'd1, 7'b0000010};
    tbl[27] = '{1'b1, 1'b1, 8'h72, 1'b0, 3'd0, 7'b0000000};

    // Reset values
    repeat (3) tick();
    chk("rst_cmd", int'(cmd), 0);
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_held", int'(held), 0);
    chk("rst_overflow", int'(overflow), 0);
    rst = 1'b1;
    repeat (2) tick();

    // Latency: cmd_valid two cycles after the strobe
    send(1'b1, 1'b0, 8'h75);
    @(negedge clk);
    chk("lat_cyc1_valid", int'(cmd_valid), 0);
    tick();
    @(negedge clk);
    chk("lat_cyc2_valid", int'(cmd_valid), 1);
    chk("lat_cyc2_cmd", int'(cmd), 0);
    chk("lat_cyc2_held", int'(held), 1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    @(negedge clk);
    chk("lat_popped", int'(cmd_valid), 0);
    tick();
    base = pop_q.size();
    send(1'b1, 1'b1, 8'h75);
    repeat (3) tick();
    chk("lat_brk_held", int'(held), 0);
    chk("lat_brk_nopush", int'(cmd_valid), 0);

    // Decode / held table
    cmd_ready = 1'b1;
    for (int i = 0; i < 28; i++) begin
      base = pop_q.size();
      send(tbl[i].ext, tbl[i].brk, tbl[i].key);
      repeat (4) tick();
      n = pop_q.size() - base;
      chk($sformatf("vec%0d_npush", i), n, int'(tbl[i].push));
      if (tbl[i].push && n > 0) chk($sformatf("vec%0d_code", i), pop_q[base], int'(tbl[i].code));
      chk($sformatf("vec%0d_held", i), int'(held), int'(tbl[i].hld));
    end

    // Auto-repeat on held RIGHT, break at +30
    repeat (3) tick();
    base = pop_q.size();
    t0 = cyc;
    send(1'b1, 1'b0, 8'h74);
    wait_until(t0 + 30);
    send(1'b1, 1'b1, 8'h74);
    wait_until(t0 + 45);
    n = pop_q.size() - base;
    chk("rep_count", n, 3);
    offs[0] = 2; offs[1] = 22; offs[2] = 27;
    for (int i = 0; i < n && i < 3; i++) begin
      chk($sformatf("rep%0d_cycle", i), pop_cyc[base + i] - t0, offs[i]);
      chk($sformatf("rep%0d_code", i), pop_q[base + i], 3);
    end
    chk("rep_held", int'(held), 0);

    // Key push colliding with repeat expiry
    base = pop_q.size();
    t0 = cyc;
    send(1'b0, 1'b0, 8'h1C);
    wait_until(t0 + 20);
    send(1'b0, 1'b0, 8'h5A);
    wait_until(t0 + 24);
    send(1'b0, 1'b1, 8'h1C);
    wait_until(t0 + 40);
    send(1'b0, 1'b1, 8'h5A);
    repeat (3) tick();
    n = pop_q.size() - base;
    chk("col_count", n, 3);
    if (n >= 3) begin
      chk("col_first_code", pop_q[base], 2);
      chk("col_key_cycle", pop_cyc[base + 1] - t0, 22);
      chk("col_key_code", pop_q[base + 1], 4);
      chk("col_rep_cycle", pop_cyc[base + 2] - t0, 23);
      chk("col_rep_code", pop_q[base + 2], 2);
    end

    // Overflow with five pushes into a depth-4 FIFO
    cmd_ready = 1'b0;
    send(1'b0, 1'b0, 8'h29); tick(); send(1'b0, 1'b1, 8'h29); tick();
    send(1'b0, 1'b0, 8'h76); tick(); send(1'b0, 1'b1, 8'h76); tick();
    send(1'b0, 1'b0, 8'h2D); tick(); send(1'b0, 1'b1, 8'h2D); tick();
    send(1'b0, 1'b0, 8'h1D); tick(); send(1'b0, 1'b1, 8'h1D); tick();
    chk("ovf_before_5th", int'(overflow), 0);
    send(1'b0, 1'b0, 8'h1B); tick(); send(1'b0, 1'b1, 8'h1B);
    repeat (3) tick();
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_head", int'(cmd), 4);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", int'(overflow), 0);
    tick();
    // Set beats clear in the same cycle
    send(1'b0, 1'b0, 8'h2D);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_set_beats_clr", int'(overflow), 1);
    tick();
    send(1'b0, 1'b1, 8'h2D);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    tick();
    chk("ovf_cleared2", int'(overflow), 0);
    drain_expect("ovf_drain", 4, 5, 6, 0);

    // Full FIFO: push and pop in the same cycle
    send(1'b0, 1'b0, 8'h76); tick(); send(1'b0, 1'b1, 8'h76); tick();
    send(1'b0, 1'b0, 8'h2D); tick(); send(1'b0, 1'b1, 8'h2D); tick();
    send(1'b0, 1'b0, 8'h5A); tick(); send(1'b0, 1'b1, 8'h5A); tick();
    send(1'b0, 1'b0, 8'h29); tick(); send(1'b0, 1'b1, 8'h29); tick();
    base = pop_q.size();
    send(1'b0, 1'b0, 8'h76);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    tick();
    chk("fpp_one_pop", pop_q.size() - base, 1);
    if (pop_q.size() > base) chk("fpp_pop_code", pop_q[base], 5);
    chk("fpp_overflow", int'(overflow), 0);
    send(1'b0, 1'b1, 8'h76); tick();
    drain_expect("fpp_drain", 6, 4, 4, 5);

    // Reset asserted mid-drain
    send(1'b0, 1'b0, 8'h1C); tick();
    send(1'b0, 1'b0, 8'h5A); tick(); send(1'b0, 1'b1, 8'h5A); tick();
    send(1'b0, 1'b0, 8'h76); tick(); send(1'b0, 1'b1, 8'h76); tick();
    send(1'b0, 1'b0, 8'h2D); tick(); send(1'b0, 1'b1, 8'h2D); tick();
    send(1'b0, 1'b0, 8'h29); tick();
    repeat (3) tick();
    chk("mid_ovf", int'(overflow), 1);
    chk("mid_held", int'(held), 7'b0010100);
    cmd_ready = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("arst_cmd_valid", int'(cmd_valid), 0);
    chk("arst_held", int'(held), 0);
    chk("arst_overflow", int'(overflow), 0);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("post_rst_empty", int'(cmd_valid), 0);
    chk("post_rst_held", int'(held), 0);
    cmd_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
